uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Byte-level command decoder between the UART receiver and the up/down counter control. It consumes one received byte per `rx_done` strobe, maps ASCII command characters to single-cycle control pulses (run/stop, clear, mode), and optionally returns a one-byte acknowledge through the UART transmitter handshake. It replaces raw `uart_data` level-sampling on the counter side with clean, one-shot commands, plus error and overrun reporting.

## Interface
- No parameters.
- `clk`  input  1  system clock
- `reset`  input  1  synchronous, active-high reset
- `rx_data`  input  8  received byte, valid in the cycle `rx_done` is high
- `rx_done`  input  1  one-cycle strobe from the UART receiver
- `tx_busy`  input  1  UART transmitter busy; rises the cycle after an accepted `tx_start`
- `tx_start`  output  1  one-cycle request to send `tx_data`
- `tx_data`  output  8  acknowledge byte, held stable while `tx_start` is high
- `cmd_run_stop`  output  1  one-cycle pulse that toggles run/stop in the counter
- `cmd_clear`  output  1  one-cycle pulse that clears the counter
- `cmd_mode`  output  1  one-cycle pulse that toggles up/down mode
- `err_cnt`  output  8  saturating count of invalid command bytes
- `overrun`  output  1  sticky flag: a byte arrived while the decoder was not in IDLE

## Operation
- States: IDLE, DECODE, SEND, WAIT_BUSY.
- IDLE: `rx_done`=1 latches `rx_data` into `byte_q` and moves to DECODE.
- DECODE lasts exactly 1 cycle. Outputs are combinational from state and `byte_q`:
  - 'R'/'r' (0x52/0x72) -> `cmd_run_stop`=1.
  - 'C'/'c' (0x43/0x63) -> `cmd_clear`=1.
  - 'M'/'m' (0x4D/0x6D) -> `cmd_mode`=1.
  - CR (0x0D) or LF (0x0A) -> ignored: no pulse, no error, no ack, next state IDLE.
  - Any other byte -> invalid: no pulse. `err_cnt` increments at the end of DECODE and saturates at 0xFF.
- Acknowledge byte: for a valid command, the received byte unchanged; for an invalid byte, '?' (0x3F).
- DECODE -> SEND for valid and invalid bytes (echo enabled). Otherwise DECODE -> IDLE.
- SEND: waits while `tx_busy`=1. When `tx_busy`=0, asserts `tx_start`=1 for 1 cycle with `tx_data`=ack, then moves to WAIT_BUSY.
- WAIT_BUSY: holds until `tx_busy`=1, then goes to IDLE.
- `rx_done`=1 in any state other than IDLE: the byte is dropped and `overrun` is set to 1. Only `reset` clears `overrun`.
- At most one `cmd_*` output is high in any cycle.

## Timing
- Reset values: state IDLE; `byte_q`=0; `tx_start`=0; `tx_data`=0x00; all `cmd_*`=0; `err_cnt`=0; `overrun`=0.
- Reset asserted mid-operation (any state) returns to IDLE on that edge. A pending ack is discarded and no pulse is emitted.
- Latency: `rx_done` high in cycle k -> `cmd_*` pulse high in cycle k+1 only.
- Echo latency with idle transmitter: `rx_done` in cycle k -> `tx_start` in cycle k+2.
- Back-to-back bytes: the earliest next accepted byte is the cycle after the return to IDLE. The receiver frame time (>10 bit periods) always exceeds this.
- `tx_data` is updated in the same cycle `tx_start` rises and holds until the next ack. It is not cleared after `tx_start`.

## Configuration
- `UART_CMD_ECHO_EN` defined: SEND and WAIT_BUSY exist and the acknowledge is sent as described.
- `UART_CMD_ECHO_EN` not defined:
  - DECODE always returns to IDLE.
  - `tx_start` and `tx_data` are tied to 0 and `tx_busy` is ignored.
  - SEND and WAIT_BUSY are not generated.
  - Decode, `err_cnt` and `overrun` behave identically.

## Structure
- Shared package `uart_cmd_pkg`:
  - state enum (IDLE, DECODE, SEND, WAIT_BUSY).
  - command enum (CMD_NONE, CMD_RUN_STOP, CMD_CLEAR, CMD_MODE, CMD_IGNORE, CMD_INVALID).
  - ASCII constants: 'R', 'r', 'C', 'c', 'M', 'm', CR, LF, '?'.
- One sub-module, `uart_cmd_lut`: purely combinational, maps a byte to the command enum. It is reused by any later UART-controlled block.
- The FSM, counters and flags live in `uart_cmd_decoder`.

## Test plan
- Reset, then 'r' strobe with `tx_busy`=0 -> `cmd_run_stop`=1 for exactly 1 cycle at k+1; `tx_start` at k+2 with `tx_data`=0x72; other `cmd_*` stay 0.
- 'C', then 'M' (spaced one frame apart) -> one `cmd_clear` pulse, then one `cmd_mode` pulse; acks 0x43, then 0x4D.
- Byte 0x41 -> no `cmd_*`; `err_cnt` 0 -> 1; ack 0x3F.
- 300 invalid bytes -> `err_cnt`=0xFF and it stays at 0xFF.
- 0x0D and 0x0A -> no pulse, no `tx_start`, `err_cnt` unchanged.
- Hold `tx_busy`=1 for 50 cycles after 'r', inject a second `rx_done` during SEND -> `overrun`=1 and the second byte produces no pulse. `tx_start` occurs only after `tx_busy` falls. Then `reset` in WAIT_BUSY -> all outputs return to reset values.
- Build without `UART_CMD_ECHO_EN`: 'r' -> pulse at k+1; `tx_start` is never asserted.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path.
// Contents: decoder state encoding, command classes, ASCII constants for
// the command characters and the acknowledge helper.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        SEND      = 2'd2,
        WAIT_BUSY = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_RUN_STOP = 3'd1,
        CMD_CLEAR    = 3'd2,
        CMD_MODE     = 3'd3,
        CMD_IGNORE   = 3'd4,
        CMD_INVALID  = 3'd5
    } cmd_e;

    localparam logic [7:0] ASCII_R_UC  = 8'h52;
    localparam logic [7:0] ASCII_R_LC  = 8'h72;
    localparam logic [7:0] ASCII_C_UC  = 8'h43;
    localparam logic [7:0] ASCII_C_LC  = 8'h63;
    localparam logic [7:0] ASCII_M_UC  = 8'h4D;
    localparam logic [7:0] ASCII_M_LC  = 8'h6D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    // Bytes that get an acknowledge: real commands echo themselves, junk gets '?'.
    function automatic logic cmd_needs_ack(input cmd_e cmd);
        return (cmd == CMD_RUN_STOP) || (cmd == CMD_CLEAR) ||
               (cmd == CMD_MODE)     || (cmd == CMD_INVALID);
    endfunction

endpackage

// File: rtl/uart_cmd_lut.sv
// Combinational byte -> command class lookup.
// Ports:
//   data : received byte
//   cmd  : command class (run/stop, clear, mode, ignore for CR/LF, invalid)
module uart_cmd_lut
    import uart_cmd_pkg::*;
(
    input  logic [7:0] data,
    output cmd_e       cmd
);

    always_comb begin
        cmd = CMD_INVALID;
        case (data)
            ASCII_R_UC, ASCII_R_LC: cmd = CMD_RUN_STOP;
            ASCII_C_UC, ASCII_C_LC: cmd = CMD_CLEAR;
            ASCII_M_UC, ASCII_M_LC: cmd = CMD_MODE;
            ASCII_CR,   ASCII_LF:   cmd = CMD_IGNORE;
            default:                cmd = CMD_INVALID;
        endcase
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received ASCII bytes into one-cycle counter
// control pulses, counts invalid bytes, flags overrun and (optionally)
// returns a one-byte acknowledge through the transmitter handshake.
//
// Build option: define UART_CMD_ECHO_EN to generate the acknowledge path
// (SEND / WAIT_BUSY states). Without it tx_start/tx_data are tied to 0.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   rx_data       : received byte, valid with rx_done
//   rx_done       : one-cycle receive strobe
//   tx_busy       : transmitter busy (ignored without echo)
//   tx_start      : one-cycle send request
//   tx_data       : acknowledge byte, held until the next acknowledge
//   cmd_run_stop  : toggle run/stop pulse
//   cmd_clear     : clear counter pulse
//   cmd_mode      : toggle up/down pulse
//   err_cnt       : saturating invalid-byte count
//   overrun       : sticky, byte received while busy decoding/sending
//
// state     | meaning
// IDLE      | waiting for rx_done, latches the byte
// DECODE    | one cycle, drives the command pulse
// SEND      | waits for tx_busy low, then pulses tx_start
// WAIT_BUSY | waits for the transmitter to take the byte
module uart_cmd_decoder
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       cmd_run_stop,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic [7:0] err_cnt,
    output logic       overrun
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_DECODE = DECODE;
`ifdef UART_CMD_ECHO_EN
    localparam logic [1:0] ST_SEND   = SEND;
    localparam logic [1:0] ST_WAIT   = WAIT_BUSY;
`endif

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] byte_q;
    cmd_e       cmd;
    logic       in_decode;

    uart_cmd_lut u_lut (
        .data (byte_q),
        .cmd  (cmd)
    );

    assign in_decode = (state_q == ST_DECODE);

    assign cmd_run_stop = in_decode && (cmd == CMD_RUN_STOP);
    assign cmd_clear    = in_decode && (cmd == CMD_CLEAR);
    assign cmd_mode     = in_decode && (cmd == CMD_MODE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_done) state_d = ST_DECODE;
            end
            ST_DECODE: begin
`ifdef UART_CMD_ECHO_EN
                state_d = cmd_needs_ack(cmd) ? ST_SEND : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef UART_CMD_ECHO_EN
            ST_SEND: begin
                if (!tx_busy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_busy) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            byte_q  <= 8'h00;
            err_cnt <= 8'h00;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && rx_done) begin
                byte_q <= rx_data;
            end
            if (in_decode && (cmd == CMD_INVALID) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            // Bytes outside IDLE are dropped; the flag stays until reset.
            if (rx_done && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef UART_CMD_ECHO_EN
    logic [7:0] ack_q;
    logic [7:0] tx_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q     <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            if (in_decode) begin
                ack_q <= (cmd == CMD_INVALID) ? ASCII_QMARK : byte_q;
            end
            if (tx_start) begin
                tx_data_q <= ack_q;
            end
        end
    end

    assign tx_start = (state_q == ST_SEND) && !tx_busy;
    // The new ack appears together with tx_start and is then held.
    assign tx_data  = tx_start ? ack_q : tx_data_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_start       = 1'b0;
    assign tx_data        = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       cmd_run_stop;
    logic       cmd_clear;
    logic       cmd_mode;
    logic [7:0] err_cnt;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int err_exp = 0;

`ifdef UART_CMD_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    uart_cmd_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .cmd_run_stop (cmd_run_stop),
        .cmd_clear    (cmd_clear),
        .cmd_mode     (cmd_mode),
        .err_cnt      (err_cnt),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference classification: 0 run/stop, 1 clear, 2 mode, 3 ignore, 4 invalid
    function automatic int classify(input logic [7:0] b);
        if (b == "R" || b == "r") return 0;
        if (b == "C" || b == "c") return 1;
        if (b == "M" || b == "m") return 2;
        if (b == 8'h0D || b == 8'h0A) return 3;
        return 4;
    endfunction

    function automatic logic [2:0] pulses_for(input int cls);
        // {run_stop, clear, mode}
        case (cls)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cls;
        logic [7:0] ack;
        cls = classify(b);
        ack = (cls == 4) ? 8'h3F : b;
        step();
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        chk("cmd_idle", {cmd_run_stop, cmd_clear, cmd_mode}, 3'b000);
        step();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        @(negedge clk);
        chk("cmd_pulse_k1", {cmd_run_stop, cmd_clear, cmd_mode}, pulses_for(cls));
        chk("tx_start_k1", tx_start, 1'b0);
        if (cls == 4) err_exp = (err_exp >= 255) ? 255 : err_exp + 1;
        step();
        @(negedge clk);
        chk("cmd_off_k2", {cmd_run_stop, cmd_clear, cmd_mode}, 3'b000);
        chk("err_cnt", err_cnt, err_exp);
        if (ECHO && cls != 3) begin
            chk("tx_start_k2", tx_start, 1'b1);
            chk("tx_data_ack", tx_data, ack);
            step();
            tx_busy = 1'b1;
            @(negedge clk);
            chk("tx_start_once", tx_start, 1'b0);
            chk("tx_data_hold", tx_data, ack);
            repeat (3) step();
            tx_busy = 1'b0;
        end else begin
            chk("tx_start_none", tx_start, 1'b0);
        end
        repeat (2) step();
    endtask

    logic [7:0] pool [10];
    logic [7:0] b;
    bit saw_start;

    initial begin
        pool[0] = "R"; pool[1] = "r"; pool[2] = "C"; pool[3] = "c"; pool[4] = "M";
        pool[5] = "m"; pool[6] = 8'h0D; pool[7] = 8'h0A; pool[8] = 8'h3F; pool[9] = 8'h41;
        reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_busy = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_cmd", {cmd_run_stop, cmd_clear, cmd_mode}, 3'b000);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_err_cnt", err_cnt, 8'h00);
        chk("rst_overrun", overrun, 1'b0);
        step();
        reset = 1'b0;

        // Directed: r, C, M, invalid 0x41, CR, LF
        send_byte("r");
        send_byte("C");
        send_byte("M");
        send_byte(8'h41);
        chk("err_after_41", err_cnt, 8'h01);
        send_byte(8'h0D);
        send_byte(8'h0A);

        // Randomized mix of commands, terminators and arbitrary bytes
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) b = pool[$urandom_range(0, 9)];
            else b = 8'($urandom);
            send_byte(b);
        end
        chk("no_overrun", overrun, 1'b0);

        // Saturation: 300 random invalid bytes
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom);
            while (classify(b) != 4) b = 8'($urandom);
            send_byte(b);
        end
        chk("err_saturated", err_cnt, 8'hFF);

        // Overrun with a byte dropped while the decoder is busy
        if (ECHO) begin
            tx_busy = 1'b1;
            step();
            rx_data = "r"; rx_done = 1'b1;
            step();
            rx_done = 1'b0;
            @(negedge clk);
            chk("ovr_first_pulse", {cmd_run_stop, cmd_clear, cmd_mode}, 3'b100);
            saw_start = 1'b0;
            for (int i = 0; i < 50; i++) begin
                step();
                if (i == 5) begin rx_data = "c"; rx_done = 1'b1; end
                else rx_done = 1'b0;
                @(negedge clk);
                if ({cmd_run_stop, cmd_clear, cmd_mode} != 3'b000 || tx_start) saw_start = 1'b1;
            end
            chk("ovr_quiet_while_busy", saw_start, 1'b0);
            chk("overrun_set", overrun, 1'b1);
            step();
            tx_busy = 1'b0;
            @(negedge clk);
            chk("ovr_tx_start", tx_start, 1'b1);
            chk("ovr_tx_data", tx_data, 8'h72);
            step();
            tx_busy = 1'b0;  // transmitter never takes it: stays in WAIT_BUSY
            @(negedge clk);
            chk("ovr_wait_no_start", tx_start, 1'b0);
        end else begin
            step();
            rx_data = "r"; rx_done = 1'b1;
            step();
            rx_data = "c"; rx_done = 1'b1;
            @(negedge clk);
            chk("ovr_first_pulse", {cmd_run_stop, cmd_clear, cmd_mode}, 3'b100);
            step();
            rx_done = 1'b0;
            @(negedge clk);
            chk("ovr_dropped", {cmd_run_stop, cmd_clear, cmd_mode}, 3'b000);
            chk("overrun_set", overrun, 1'b1);
            chk("tx_start_never", tx_start, 1'b0);
        end

        // Reset mid-operation
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_cmd", {cmd_run_stop, cmd_clear, cmd_mode}, 3'b000);
        chk("rst2_tx_start", tx_start, 1'b0);
        chk("rst2_tx_data", tx_data, 8'h00);
        chk("rst2_err_cnt", err_cnt, 8'h00);
        chk("rst2_overrun", overrun, 1'b0);
        err_exp = 0;
        repeat (3) step();
        @(negedge clk);
        chk("rst2_idle_start", tx_start, 1'b0);

        // Decoder works normally after reset
        send_byte("m");
        send_byte(8'h7E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
